pgm_ddram_arb: RTL and testbench
================================

# pgm_ddram_arb

Three-way arbiter sharing the single 64-bit DDRAM read port between the sprite line fetcher, the background tile fetcher and the 68K program-ROM path. It sits between `pgm_video` / CPU bus logic and the MiSTer DDRAM bridge. It keeps one read outstanding at a time, returns each 64-bit beat to the requester that issued it, and recovers from a lost `ddram_dout_ready` with a watchdog.

## Interface
- `TO_W`, 10: width of watchdog counter; timeout fires after 2^TO_W−1 cycles in WAIT.
- `clk` in 1: single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `spr_req` / `bg_req` / `cpu_req` in 1 each: level request, held until the matching `*_valid`.
- `spr_addr` / `bg_addr` / `cpu_addr` in 29 each: DDRAM word address, stable while the request is high.
- `spr_valid` / `bg_valid` / `cpu_valid` out 1 each: one-cycle pulse; `rdata` is valid this cycle.
- `rdata` out 64: shared returned data, registered.
- `timeout` out 1: one-cycle pulse, coincident with the `*_valid` of a timed-out transaction.
- `active_id` out 2: 0 = sprite, 1 = bg, 2 = cpu, 3 = idle.
- `ddram_rd` out 1: read strobe.
- `ddram_addr` out 29: read address.
- `ddram_busy` in 1: bridge stall.
- `ddram_dout` in 64: read data.
- `ddram_dout_ready` in 1: read data valid.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request is high, select a winner, latch its id and address, set `ddram_rd=1` and `ddram_addr`, then go to ISSUE.
  - Otherwise `active_id=3`.
- ISSUE:
  - Hold `ddram_rd` and `ddram_addr` until a cycle with `ddram_busy=0`. That cycle is the accept.
  - On the next cycle `ddram_rd=0`, the watchdog clears, and the FSM moves to WAIT.
- WAIT:
  - On `ddram_dout_ready=1`, register `ddram_dout` into `rdata`, pulse the winner's `*_valid` next cycle, and return to IDLE.
  - If the watchdog reaches 2^TO_W−1, set `rdata=0`, pulse the winner's `*_valid` together with `timeout`, and return to IDLE.
- Arbitration is fixed priority: sprite > bg > cpu. It is evaluated only in IDLE.
- Requests are not re-sampled during ISSUE or WAIT.
- A requester that drops its request before its valid is a protocol violation. The transaction still completes and the valid still pulses.
- `ddram_dout_ready` outside WAIT (for example, a late beat after a timeout) is ignored; `rdata` and the valids are unchanged.
- A request held high on the cycle after its valid is treated as a new request.
- Reset values: `ddram_rd=0`, `ddram_addr=0`, `rdata=0`, all `*_valid=0`, `timeout=0`, `active_id=3`, FSM=IDLE, watchdog=0, RR pointer=cpu (so sprite is first under RR).
- Reset asserted mid-transaction abandons it; no valid is pulsed.

## Timing
- Request high in IDLE at cycle 0 → `ddram_rd=1` from cycle 1.
- With `ddram_busy=0` at cycle 1, `ddram_rd=0` at cycle 2.
- `ddram_dout_ready` at cycle N in WAIT → `*_valid` and `rdata` at N+1. The FSM is IDLE at N+1.
- The next grant's `ddram_rd` rises at N+2 at the earliest, so at most one read is in flight.
- `active_id` updates on the same edge as the grant and returns to 3 on the valid edge.
- Watchdog counts cycles in WAIT only; saturation at 2^TO_W−1 triggers the timeout on the following edge.

## Configuration
- `PGM_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at the requester after the last winner (sprite→bg→cpu→sprite).
  - The pointer updates on each grant.
  - Every continuously requesting source is served within 3 grants.
- `PGM_ARB_RR_EN` undefined: fixed priority sprite > bg > cpu. No pointer register.

## Test plan
- Single sprite read:
  - Stimulus: `spr_addr=0x0001234`, busy low, dout_ready 5 cycles after accept with data 0xDEADBEEF_CAFEF00D.
  - Response: `ddram_addr=0x0001234`, `ddram_rd` high exactly 1 cycle, `spr_valid` 1 cycle with that `rdata`, `active_id` 0 then 3.
- Busy stall:
  - Stimulus: `bg_req` with `ddram_busy` high for 4 cycles.
  - Response: `ddram_rd` and `ddram_addr` held 5 cycles, then drop after the accept.
- Simultaneous requests, all three asserted continuously:
  - Fixed priority: grant order sprite, sprite, sprite…
  - With `PGM_ARB_RR_EN`: grant order sprite, bg, cpu, sprite.
- Watchdog, `TO_W=4`:
  - Stimulus: `cpu_req`, no `dout_ready`.
  - Response: `cpu_valid` and `timeout` at cycle 15 of WAIT, with `rdata=0`.
  - Follow-up: a late `dout_ready` changes nothing.
- Reset mid-WAIT:
  - Stimulus: `reset_n` low for 1 cycle.
  - Response: all outputs return to reset values immediately; no `*_valid`; a new `bg_req` after release is served normally.
- Back-to-back: after `spr_valid`, `spr_req` is held → the second `ddram_rd` rises exactly 1 cycle after the valid.

Source files
------------

// File: rtl/pgm_ddram_arb.sv
// rtl/pgm_ddram_arb.sv - three-way DDRAM read-port arbiter (sprite / bg / cpu)
//
// Purpose: shares one 64-bit DDRAM read port between the sprite line fetcher,
// the background tile fetcher and the 68K program-ROM path. One read is in
// flight at a time; the returned beat goes to the requester that issued it.
// A watchdog completes a transaction whose ddram_dout_ready never arrives.
//
// Optional feature: define PGM_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority sprite > bg > cpu.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   spr/bg/cpu_req, *_addr        level requests and 29-bit word addresses
//   spr/bg/cpu_valid              one-cycle return pulse, rdata valid with it
//   rdata                         registered returned data (0 on timeout)
//   timeout                       pulses with the valid of a timed-out read
//   active_id                     0 sprite, 1 bg, 2 cpu, 3 idle
//   ddram_rd, ddram_addr          read strobe and address to the bridge
//   ddram_busy                    bridge stall
//   ddram_dout, ddram_dout_ready  read data and its strobe
module pgm_ddram_arb #(
  parameter int TO_W = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spr_req,
  input  logic        bg_req,
  input  logic        cpu_req,
  input  logic [28:0] spr_addr,
  input  logic [28:0] bg_addr,
  input  logic [28:0] cpu_addr,
  output logic        spr_valid,
  output logic        bg_valid,
  output logic        cpu_valid,
  output logic [63:0] rdata,
  output logic        timeout,
  output logic [1:0]  active_id,
  output logic        ddram_rd,
  output logic [28:0] ddram_addr,
  input  logic        ddram_busy,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  // Watchdog fires on the edge where the counter would reach all-ones,
  // i.e. after 2^TO_W-1 cycles spent in WAIT.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_e            state_q;
  logic              rd_q;
  logic [28:0]       addr_q;
  logic [63:0]       rdata_q;
  logic [2:0]        valid_q;
  logic              timeout_q;
  logic [1:0]        id_q;
  logic [TO_W-1:0]   wd_q;

  logic [2:0]        req_vec;
  logic              grant_d;
  logic [1:0]        win_d;
  logic [28:0]       win_addr_d;

  assign req_vec = {cpu_req, bg_req, spr_req};

`ifdef PGM_ARB_RR_EN
  logic [1:0] rr_q;
  logic [1:0] c0, c1, c2;

  // Search order starts at the requester after the last winner.
  always_comb begin
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    case (rr_q)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
  end

  always_comb begin
    win_d = 2'd3;
    if (req_vec[c0])      win_d = c0;
    else if (req_vec[c1]) win_d = c1;
    else if (req_vec[c2]) win_d = c2;
  end
`else
  always_comb begin
    win_d = 2'd3;
    if (spr_req)      win_d = 2'd0;
    else if (bg_req)  win_d = 2'd1;
    else if (cpu_req) win_d = 2'd2;
  end
`endif

  always_comb begin
    grant_d = |req_vec;
    case (win_d)
      2'd0:    win_addr_d = spr_addr;
      2'd1:    win_addr_d = bg_addr;
      default: win_addr_d = cpu_addr;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
      valid_q   <= 3'b000;
      timeout_q <= 1'b0;
      id_q      <= 2'd3;
      wd_q      <= '0;
`ifdef PGM_ARB_RR_EN
      rr_q      <= 2'd2;
`endif
    end else begin
      valid_q   <= 3'b000;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            rd_q    <= 1'b1;
            addr_q  <= win_addr_d;
            id_q    <= win_d;
            state_q <= ST_ISSUE;
`ifdef PGM_ARB_RR_EN
            rr_q    <= win_d;
`endif
          end
        end
        ST_ISSUE: begin
          if (!ddram_busy) begin
            rd_q    <= 1'b0;
            wd_q    <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A beat arriving on the last watchdog cycle still wins.
          if (ddram_dout_ready) begin
            rdata_q <= ddram_dout;
            valid_q <= 3'b001 << id_q;
            id_q    <= 2'd3;
            state_q <= ST_IDLE;
          end else if (wd_q == WD_LAST) begin
            rdata_q   <= '0;
            valid_q   <= 3'b001 << id_q;
            timeout_q <= 1'b1;
            id_q      <= 2'd3;
            wd_q      <= wd_q + 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spr_valid  = valid_q[0];
  assign bg_valid   = valid_q[1];
  assign cpu_valid  = valid_q[2];
  assign rdata      = rdata_q;
  assign timeout    = timeout_q;
  assign active_id  = id_q;
  assign ddram_rd   = rd_q;
  assign ddram_addr = addr_q;

endmodule

// File: tb/tb_pgm_ddram_arb.sv
// tb/tb_pgm_ddram_arb.sv - self-checking bench for pgm_ddram_arb
module tb_pgm_ddram_arb;

  localparam int TO_W   = 4;
  localparam int WD_CYC = (1 << TO_W) - 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spr_req, bg_req, cpu_req;
  logic [28:0] spr_addr, bg_addr, cpu_addr;
  logic        spr_valid, bg_valid, cpu_valid;
  logic [63:0] rdata;
  logic        timeout;
  logic [1:0]  active_id;
  logic        ddram_rd;
  logic [28:0] ddram_addr;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: pending level requests and their addresses.
  logic        pend [3];
  logic [28:0] areq [3];

  always #5 clk = ~clk;

  pgm_ddram_arb #(.TO_W(TO_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .spr_req          (spr_req),
    .bg_req           (bg_req),
    .cpu_req          (cpu_req),
    .spr_addr         (spr_addr),
    .bg_addr          (bg_addr),
    .cpu_addr         (cpu_addr),
    .spr_valid        (spr_valid),
    .bg_valid         (bg_valid),
    .cpu_valid        (cpu_valid),
    .rdata            (rdata),
    .timeout          (timeout),
    .active_id        (active_id),
    .ddram_rd         (ddram_rd),
    .ddram_addr       (ddram_addr),
    .ddram_busy       (ddram_busy),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    spr_req  = pend[0];
    bg_req   = pend[1];
    cpu_req  = pend[2];
    spr_addr = areq[0];
    bg_addr  = areq[1];
    cpu_addr = areq[2];
  endtask

  // Fixed priority: first pending requester in the order sprite, bg, cpu.
  function automatic int pick();
    for (int i = 0; i < 3; i++) if (pend[i]) return i;
    return 3;
  endfunction

  function automatic logic [63:0] vals();
    return 64'({cpu_valid, bg_valid, spr_valid});
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"},    64'(ddram_rd),   64'd0);
    chk({tag, "_addr"},  64'(ddram_addr), 64'd0);
    chk({tag, "_rdata"}, rdata,           64'd0);
    chk({tag, "_valid"}, vals(),          64'd0);
    chk({tag, "_tmo"},   64'(timeout),    64'd0);
    chk({tag, "_id"},    64'(active_id),  64'd3);
  endtask

  // One transaction from an IDLE arbiter. busy_n stall cycles before accept,
  // beat arrives at WAIT cycle lat (never if lat < 0 or lat >= WD_CYC).
  // hold keeps the winner requesting after its valid (a new request).
  task automatic run_txn(input int busy_n, input int lat, input logic [63:0] data, input bit hold);
    int          w;
    logic [28:0] a;
    bit          done;
    drive();
    w = pick();
    a = areq[w];
    step();
    for (int i = 0; i <= busy_n; i++) begin
      ddram_busy = (i < busy_n);
      chk("rd_held",   64'(ddram_rd),   64'd1);
      chk("rd_addr",   64'(ddram_addr), 64'(a));
      chk("grant_id",  64'(active_id),  64'(w));
      chk("no_valid",  vals(),          64'd0);
      step();
    end
    ddram_busy = 1'($urandom_range(0, 1));
    chk("rd_drop", 64'(ddram_rd), 64'd0);
    done = 1'b0;
    for (int k = 0; k < WD_CYC && !done; k++) begin
      ddram_dout_ready = (k == lat);
      ddram_dout       = (k == lat) ? data : {$urandom, $urandom};
      step();
      ddram_dout_ready = 1'b0;
      if (k == lat || k == WD_CYC - 1) begin
        done = 1'b1;
        chk("valid_onehot", vals(),         64'(3'b001 << w));
        chk("rdata",        rdata,          (k == lat) ? data : 64'd0);
        chk("timeout",      64'(timeout),   64'(k != lat));
        chk("id_idle",      64'(active_id), 64'd3);
        chk("rd_low",       64'(ddram_rd),  64'd0);
      end else begin
        chk("wait_valid", vals(),         64'd0);
        chk("wait_tmo",   64'(timeout),   64'd0);
        chk("wait_id",    64'(active_id), 64'(w));
      end
    end
    ddram_busy = 1'b0;
    if (!hold) pend[w] = 1'b0;
    drive();
  endtask

  initial begin
    int          b, l;
    bit          h;
    logic [63:0] d;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0;
      areq[i] = '0;
    end
    drive();
    ddram_busy       = 1'b0;
    ddram_dout       = '0;
    ddram_dout_ready = 1'b0;
    step();
    step();
    chk_reset_outs("reset");
    reset_n = 1'b1;
    step();
    chk_reset_outs("idle");

    // Single sprite read: beat 5 cycles after accept.
    pend[0] = 1'b1;
    areq[0] = 29'h0001234;
    run_txn(0, 4, 64'hDEADBEEF_CAFEF00D, 1'b0);
    step();
    chk("spr_valid_once", vals(),         64'd0);
    chk("spr_id_idle",    64'(active_id), 64'd3);
    chk("spr_rd_idle",    64'(ddram_rd),  64'd0);
    chk("spr_rdata_keep", rdata,          64'hDEADBEEF_CAFEF00D);

    // Busy stall on a bg request: strobe held for 5 cycles.
    pend[1] = 1'b1;
    areq[1] = 29'h0ABCDEF;
    run_txn(4, 2, 64'h0123_4567_89AB_CDEF, 1'b0);

    // All three continuously requesting: sprite keeps winning back-to-back,
    // then bg and cpu once sprite lets go.
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b1;
      areq[i] = 29'(32'h100 * (i + 1));
    end
    for (int n = 0; n < 3; n++) run_txn(0, 1, {$urandom, $urandom}, 1'b1);
    run_txn(0, 1, {$urandom, $urandom}, 1'b0);
    run_txn(1, 0, {$urandom, $urandom}, 1'b0);
    run_txn(0, 3, {$urandom, $urandom}, 1'b0);

    // Watchdog on a cpu read, then a late beat must be ignored.
    pend[2] = 1'b1;
    areq[2] = 29'h1FFF_FFFF;
    run_txn(0, -1, 64'd0, 1'b0);
    ddram_dout_ready = 1'b1;
    ddram_dout       = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("late_rdata", rdata,          64'd0);
      chk("late_valid", vals(),         64'd0);
      chk("late_id",    64'(active_id), 64'd3);
      chk("late_rd",    64'(ddram_rd),  64'd0);
    end
    ddram_dout_ready = 1'b0;

    // Reset in the middle of WAIT abandons the read.
    pend[1] = 1'b1;
    areq[1] = 29'h0055AA0;
    drive();
    step();
    ddram_busy = 1'b0;
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    pend[1] = 1'b0;
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    chk_reset_outs("post_reset");
    pend[1] = 1'b1;
    areq[1] = 29'h0077700;
    run_txn(1, 3, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0);

    // Randomized traffic against the priority model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          areq[i] = 29'($urandom);
        end
      end
      if (pick() == 3) begin
        b = $urandom_range(0, 2);
        pend[b] = 1'b1;
        areq[b] = 29'($urandom);
      end
      b = $urandom_range(0, 3);
      l = $urandom_range(0, 18);
      d = {$urandom, $urandom};
      h = ($urandom_range(0, 3) == 0);
      run_txn(b, l, d, h);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
